// File: rtl/wb_regfile.sv
// MIPS write-back stage: MEM/WB pipeline latch feeding a 32-entry register file
// with two combinational read ports and WB-to-ID bypass.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_reg_write_en,
    input  logic [ADDR_WIDTH-1:0] mem_reg_addr,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  wb_write_en,
    output logic [ADDR_WIDTH-1:0] wb_reg_addr,
    output logic [DATA_WIDTH-1:0] wb_data
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // MEM/WB latch: the architectural outputs double as the pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_write_en <= 1'b0;
            wb_reg_addr <= '0;
            wb_data     <= '0;
        end else if (!stall) begin
            wb_write_en <= mem_reg_write_en;
            wb_reg_addr <= mem_reg_addr;
            wb_data     <= mem_data_in;
        end
    end

    // Commit of the pre-edge latch entry; a reset on the same edge discards it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write_en && (wb_reg_addr != '0)) begin
            regs[wb_reg_addr] <= wb_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_sel(
        input logic                  rst_i,
        input logic                  re,
        input logic [ADDR_WIDTH-1:0] ra,
        input logic                  byp_en,
        input logic [ADDR_WIDTH-1:0] byp_addr,
        input logic [DATA_WIDTH-1:0] byp_data,
        input logic [DATA_WIDTH-1:0] arr_data
    );
        logic [DATA_WIDTH-1:0] r;
        if (rst_i || !re || (ra == '0)) begin
            r = '0;
        end else if (byp_en && (byp_addr == ra)) begin
            r = byp_data;
        end else begin
            r = arr_data;
        end
        return r;
    endfunction

    always_comb begin
        rdata1 = read_sel(rst, re1, raddr1, wb_write_en, wb_reg_addr, wb_data, regs[raddr1]);
        rdata2 = read_sel(rst, re2, raddr2, wb_write_en, wb_reg_addr, wb_data, regs[raddr2]);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, bypass, r0, dual port,
// back-to-back writes with stall, and reset discarding a pending entry.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [DW-1:0] mem_data_in;
    logic          mem_reg_write_en;
    logic [AW-1:0] mem_reg_addr;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic          wb_write_en;
    logic [AW-1:0] wb_reg_addr;
    logic [DW-1:0] wb_data;

    int n_cmp;
    int n_fail;

    wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .mem_data_in      (mem_data_in),
        .mem_reg_write_en (mem_reg_write_en),
        .mem_reg_addr     (mem_reg_addr),
        .re1              (re1),
        .raddr1           (raddr1),
        .rdata1           (rdata1),
        .re2              (re2),
        .raddr2           (raddr2),
        .rdata2           (rdata2),
        .wb_write_en      (wb_write_en),
        .wb_reg_addr      (wb_reg_addr),
        .wb_data          (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_reg_write_en = we;
        mem_reg_addr     = a;
        mem_data_in      = d;
    endtask

    task automatic test_reset();
        // fill some registers and leave a pending entry in the latch
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mem_drive(1'b1, 5'd1, 32'h0000_0111);
        tick();
        mem_drive(1'b1, 5'd2, 32'h0000_0222);
        tick();
        mem_drive(1'b1, 5'd8, 32'h0000_0088);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        re1 = 1'b1;
        raddr1 = 5'd8;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_forces_rdata1: got %h want %h", rdata1, 32'h0);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (wb_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wb_write_en: got %b want 0", wb_write_en);
        end
        n_cmp++;
        if (wb_reg_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_wb_reg_addr: got %0d want 0", wb_reg_addr);
        end
        n_cmp++;
        if (wb_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wb_data: got %h want 0", wb_data);
        end
        re2 = 1'b1;
        for (int i = 1; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            #1;
            n_cmp++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg_r%0d: got %h/%h want 0/0", i, rdata1, rdata2);
            end
        end
        re2 = 1'b0;
    endtask

    task automatic test_basic_write();
        mem_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        re1 = 1'b1;
        raddr1 = 5'd5;
        #1;
        n_cmp++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_bypass: got %h want %h", rdata1, 32'hDEAD_BEEF);
        end
        n_cmp++;
        if (wb_write_en !== 1'b1 || wb_reg_addr !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_wb_latch: got %b/%0d/%h want 1/5/deadbeef", wb_write_en, wb_reg_addr, wb_data);
        end
        tick();
        n_cmp++;
        if (wb_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latch_refill: got %b want 0", wb_write_en);
        end
        n_cmp++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_array_read: got %h want %h", rdata1, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_r0();
        mem_drive(1'b1, 5'd0, 32'h1234_5678);
        re1 = 1'b1;
        raddr1 = 5'd0;
        re2 = 1'b1;
        raddr2 = 5'd0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_before: got %h want 0", rdata1);
        end
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        #1;
        n_cmp++;
        if (wb_write_en !== 1'b1 || wb_reg_addr !== 5'd0 || wb_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL r0_latch: got %b/%0d/%h want 1/0/12345678", wb_write_en, wb_reg_addr, wb_data);
        end
        n_cmp++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_bypass_cycle: got %h/%h want 0/0", rdata1, rdata2);
        end
        tick();
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_after_commit: got %h want 0", rdata1);
        end
        re2 = 1'b0;
    endtask

    task automatic test_dual_port();
        mem_drive(1'b1, 5'd3, 32'h0000_000A);
        tick();
        mem_drive(1'b1, 5'd7, 32'h0000_000B);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        tick();
        tick();
        re1 = 1'b1;
        raddr1 = 5'd3;
        re2 = 1'b1;
        raddr2 = 5'd7;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0000_000A) begin
            n_fail++;
            $display("FAIL dual_rdata1: got %h want 0000000a", rdata1);
        end
        n_cmp++;
        if (rdata2 !== 32'h0000_000B) begin
            n_fail++;
            $display("FAIL dual_rdata2: got %h want 0000000b", rdata2);
        end
        re2 = 1'b0;
        #1;
        n_cmp++;
        if (rdata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL dual_re2_off: got %h want 0", rdata2);
        end
        n_cmp++;
        if (rdata1 !== 32'h0000_000A) begin
            n_fail++;
            $display("FAIL dual_rdata1_kept: got %h want 0000000a", rdata1);
        end
        re1 = 1'b0;
        #1;
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL dual_re1_off: got %h want 0", rdata1);
        end
    endtask

    task automatic test_back_to_back();
        re1 = 1'b1;
        raddr1 = 5'd9;
        re2 = 1'b1;
        raddr2 = 5'd9;
        mem_drive(1'b1, 5'd9, 32'd1);
        tick();
        n_cmp++;
        if (rdata1 !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_bypass_1: got %h want 1", rdata1);
        end
        mem_drive(1'b1, 5'd9, 32'd2);
        tick();
        n_cmp++;
        if (rdata1 !== 32'd2 || rdata2 !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_bypass_2: got %h/%h want 2/2", rdata1, rdata2);
        end
        stall = 1'b1;
        mem_drive(1'b1, 5'd9, 32'd3);
        tick();
        n_cmp++;
        if (wb_write_en !== 1'b1 || wb_reg_addr !== 5'd9 || wb_data !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_hold_latch: got %b/%0d/%h want 1/9/2", wb_write_en, wb_reg_addr, wb_data);
        end
        n_cmp++;
        if (rdata1 !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_hold_read: got %h want 2", rdata1);
        end
        tick();
        n_cmp++;
        if (wb_data !== 32'd2 || rdata1 !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_hold_2nd: got %h/%h want 2/2", wb_data, rdata1);
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (wb_data !== 32'd3 || rdata1 !== 32'd3 || rdata2 !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_release: got %h/%h/%h want 3/3/3", wb_data, rdata1, rdata2);
        end
        mem_drive(1'b0, 5'd0, 32'h0);
        tick();
        n_cmp++;
        if (rdata1 !== 32'd3) begin
            n_fail++;
            $display("FAIL b2b_array_final: got %h want 3", rdata1);
        end
        re2 = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        mem_drive(1'b1, 5'd4, 32'h0000_0055);
        tick();
        n_cmp++;
        if (wb_write_en !== 1'b1 || wb_reg_addr !== 5'd4) begin
            n_fail++;
            $display("FAIL midrst_pending: got %b/%0d want 1/4", wb_write_en, wb_reg_addr);
        end
        mem_drive(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        re1 = 1'b1;
        raddr1 = 5'd4;
        #1;
        n_cmp++;
        if (wb_write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_wb_write_en: got %b want 0", wb_write_en);
        end
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_r4: got %h want 0", rdata1);
        end
        tick();
        n_cmp++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_r4_later: got %h want 0", rdata1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        stall = 1'b0;
        re1 = 1'b0;
        re2 = 1'b0;
        raddr1 = '0;
        raddr2 = '0;
        mem_drive(1'b0, 5'd0, 32'h0);
        test_reset();
        test_basic_write();
        test_r0();
        test_dual_port();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MIPS pipeline: consumes the MEM-stage result (data, write enable, destination register), holds it in a MEM/WB pipeline register, and commits it to a 32-entry general-purpose register file.
- Provides two combinational read ports for the ID stage.
- Each read port has WB-to-ID bypass, so an operand written by the instruction currently in WB is visible in the same cycle.

Parameters:
DATA_WIDTH, 32, register and data width
ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH (32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high (rst==`RstEnable), sampled on rising edge of clk
stall  input  1  1 = hold MEM/WB pipeline register
mem_data_in  input  DATA_WIDTH  result from MEM stage
mem_reg_write_en  input  1  MEM-stage register write enable
mem_reg_addr  input  ADDR_WIDTH  MEM-stage destination register
re1  input  1  read enable, port 1
raddr1  input  ADDR_WIDTH  read index, port 1
rdata1  output  DATA_WIDTH  read data, port 1 (combinational)
re2  input  1  read enable, port 2
raddr2  input  ADDR_WIDTH  read index, port 2
rdata2  output  DATA_WIDTH  read data, port 2 (combinational)
wb_write_en  output  1  current MEM/WB write enable (registered)
wb_reg_addr  output  ADDR_WIDTH  current MEM/WB destination (registered)
wb_data  output  DATA_WIDTH  current MEM/WB data (registered)

Behaviour:
- Reset: any rising edge with rst==`RstEnable clears wb_write_en=0, wb_reg_addr=0, wb_data=0 and all 32 registers to 0.
  - While rst is high, rdata1 and rdata2 are forced to 0.
  - Reset asserted mid-operation discards the pending MEM/WB entry; it is never committed.
- MEM/WB latch: on a rising edge with rst low and stall=0, the latch loads {mem_reg_write_en, mem_reg_addr, mem_data_in}.
  - stall=1 holds the current latch contents.
- Commit: on every rising edge with rst low, if wb_write_en=1 and wb_reg_addr!=0, then regs[wb_reg_addr] <= wb_data.
  - Commit uses the pre-edge latch value, so latch load and commit of the previous entry happen on the same edge.
  - Under stall, the held entry re-commits each cycle with the same value, which is harmless.
- Latency:
  - A MEM input sampled at edge N appears on wb_* after edge N.
  - It is written into the array at edge N+1.
  - It is readable via bypass in cycle N..N+1, and from the array from N+1 on.
- Register 0 is hardwired to zero:
  - writes to index 0 are dropped;
  - reads of index 0 return 0 even when wb_write_en=1 and wb_reg_addr=0.
- Read port k (k=1,2), fully combinational, evaluated in priority order:
  - rst high -> 0
  - re_k=0 -> 0
  - raddr_k==0 -> 0
  - wb_write_en=1 and wb_reg_addr==raddr_k -> wb_data (bypass)
  - otherwise -> regs[raddr_k]
- The two read ports are independent; both may read the same index, including the bypassed index, in the same cycle.
- mem_* inputs never bypass directly to read ports. Forwarding from EX and MEM is handled elsewhere.
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset: drive rst=1 for 1 edge with stale contents -> wb_write_en=0, wb_reg_addr=0, wb_data=0, and reads of r1..r31 return 0.
- Basic write/read: MEM presents we=1, addr=5, data=0xDEADBEEF at edge N.
  - In cycle N+1, rdata1(raddr1=5, re1=1) = 0xDEADBEEF via bypass.
  - After edge N+1, with the latch refilled by we=0, rdata1 still = 0xDEADBEEF from the array.
- r0 protection: write we=1, addr=0, data=0x12345678 -> rdata1(raddr=0) = 0 in every cycle, including the bypass cycle.
- Read enable and dual port: regs[3]=0xA, regs[7]=0xB.
  - re1=1/raddr1=3 and re2=1/raddr2=7 -> rdata1=0xA, rdata2=0xB.
  - Dropping re2 to 0 -> rdata2=0.
- Back-to-back and stall:
  - Consecutive writes r9=1 then r9=2 -> array ends at 2, with bypass showing 1 then 2.
  - stall=1 while MEM changes to r9=3 -> wb_* hold r9=2 and rdata for r9 stays 2.
  - Releasing stall -> 3 appears the next cycle.
- Reset mid-operation: latch holds we=1, addr=4, data=0x55 and rst=1 at the next edge -> regs[4]=0 and wb_write_en=0, i.e. the entry is never committed.
